switch_event_scheduler: RTL and testbench
=========================================

Name: switch_event_scheduler

Overview:
Scans N_CH raw slide switches or pushbuttons using one shared sample-tick timebase and debounces each channel with a per-channel stable-sample counter. It turns every committed level change into a single event and schedules pending events round-robin onto one valid/ready event port. The block sits between the board switch pins and the game/control FSMs. It replaces per-switch free-running debouncers with one sequenced resource.

Parameters:
N_CH, 17, number of switch channels (1..32)
CH_W, 5, width of channel index; 2^CH_W >= N_CH
TICK_DIV, 50000, clk cycles per sample tick (>=2)
STABLE_CNT, 4, consecutive differing samples required to commit a change (2..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
sw_in  in  N_CH  raw asynchronous switch levels
sw_state  out  N_CH  debounced committed levels
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_ch  out  CH_W  channel index of presented event
evt_level  out  1  committed level of evt_ch at grant
evt_overrun  out  N_CH  sticky per-channel lost-event flags (see Optional Feature)
ovr_clr  in  1  single-cycle pulse, clears evt_overrun

Behaviour:
- Reset (rst=1, async): clears sync flops, sw_state, stable counters, pending, prescaler, rr_ptr, evt_valid, evt_ch, evt_level and evt_overrun to 0. All pending events are dropped, including during reset mid-handshake.
- Synchronizer: 2 flops per channel. s = second stage.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick=1 for one cycle when count==TICK_DIV-1.
- Per channel i, acting only on tick:
  - s==sw_state[i]: cnt<=0.
  - otherwise, if cnt==STABLE_CNT-1: sw_state[i]<=s, cnt<=0, pending[i]<=1 (commit).
  - otherwise cnt<=cnt+1.
  - Any agreeing sample restarts the count, so bounces shorter than STABLE_CNT ticks produce nothing.
- Commit latency: a clean edge reaches sw_state after 2 sync cycles plus STABLE_CNT ticks.
- Arbiter FSM, states IDLE and PRESENT; unused encodings recover to IDLE.
- IDLE:
  - If pending!=0, grant g = first set index searching rr_ptr, rr_ptr+1, ..., N_CH-1, 0, ..., rr_ptr-1.
  - Registers evt_ch<=g, evt_level<=sw_state[g], evt_valid<=1, pending[g]<=0, then goes to PRESENT.
  - An event appears 1 cycle after pending sets.
- PRESENT:
  - evt_valid, evt_ch and evt_level are held stable until evt_ready=1.
  - On handshake: evt_valid<=0, rr_ptr<=(g==N_CH-1)?0:g+1, go to IDLE.
  - Back-to-back events are separated by at least one idle cycle.
  - evt_ready while evt_valid=0 is ignored.
- Simultaneous set and clear of pending[g] in the grant cycle: set wins, so a new event follows later.
- A channel changing again while its event is presented raises a fresh pending. evt_level is never updated in place.
- Multiple commits on the same tick all set pending and are served in round-robin order.

Optional Feature:
- Macro SWITCH_EVT_OVERRUN_EN.
- Defined:
  - A commit on channel i while pending[i] is already 1 sets evt_overrun[i]=1 (sticky).
  - ovr_clr=1 clears all bits next edge. A same-cycle overrun set wins over the clear.
- Undefined: evt_overrun is constant 0 and ovr_clr is ignored. Port list is unchanged.

Test Plan:
1. Bench uses TICK_DIV=4, STABLE_CNT=3. Assert rst mid-cycle with sw_in=all-ones -> immediately evt_valid=0, sw_state=0, evt_ch=0. After release, no event before 2 cycles + 3 ticks.
2. sw_in[3] 0->1 held; evt_ready=0 for 5 cycles, then 1 -> sw_state[3]=1 after 2+12 cycles; evt_valid=1, evt_ch=3, evt_level=1 held stable all 5 cycles; evt_valid=0 the cycle after ready.
3. sw_in[0] toggles every tick for 8 ticks, then returns to 0 -> sw_state[0] stays 0, evt_valid never asserts.
4. rr_ptr=0; ch1 and ch5 commit on the same tick; ready=1 -> events ch1 then ch5 (rr_ptr=6). Then ch0 and ch7 commit together -> ch7 first, then ch0.
5. With SWITCH_EVT_OVERRUN_EN: ch2 commits 1 and is granted; ready held 0; ch2 commits 0, then 1 -> evt_overrun[2]=1, sticky. ovr_clr pulse -> 0. Build without the macro: same stimulus, evt_overrun stays 0.
6. Boundary: N_CH=17, ch16 granted with rr_ptr=16 -> rr_ptr wraps to 0. Pending on ch16 set in the same cycle as its grant clear -> second ch16 event follows.

Source files
------------

// File: rtl/switch_event_scheduler.sv
// Shared-tick debouncer for N_CH switches feeding one round-robin valid/ready event port.
// Define SWITCH_EVT_OVERRUN_EN to enable the sticky per-channel lost-event flags.
module switch_event_scheduler #(
   parameter int N_CH       = 17,
   parameter int CH_W       = 5,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] sw_in,
   output logic [N_CH-1:0] sw_state,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [CH_W-1:0] evt_ch,
   output logic            evt_level,
   output logic [N_CH-1:0] evt_overrun,
   input  logic            ovr_clr
);
   localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [3:0]         CNT_LAST   = 4'(STABLE_CNT - 1);
   localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(N_CH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b01,
      PRESENT = 2'b10
   } arb_state_t;

   logic [N_CH-1:0]    sync1_reg;
   logic [N_CH-1:0]    sync2_reg;
   logic [N_CH-1:0]    sw_state_reg;
   logic [N_CH-1:0]    pending_reg;
   logic [N_CH-1:0]    pending_next;
   logic [N_CH-1:0]    commit;
   logic [N_CH-1:0]    grant_clr;
   logic [PRESC_W-1:0] presc_reg;
   logic               tick;

   arb_state_t         state_reg;
   arb_state_t         state_next;
   logic               evt_valid_reg;
   logic               evt_valid_next;
   logic [CH_W-1:0]    evt_ch_reg;
   logic [CH_W-1:0]    evt_ch_next;
   logic               evt_level_reg;
   logic               evt_level_next;
   logic [CH_W-1:0]    rr_ptr_reg;
   logic [CH_W-1:0]    rr_ptr_next;

   logic               grant_found;
   logic [CH_W-1:0]    grant_ch;
   int                 scan_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= sw_in;
         sync2_reg <= sync1_reg;
      end
   end

   assign tick = (presc_reg == PRESC_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_reg <= '0;
      end else if (tick) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + 1'b1;
      end
   end

   // Each channel counts consecutive ticks on which the synchronized level
   // disagrees with its committed level; any agreeing sample restarts it.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [3:0] cnt_reg;
         logic       differ;

         assign differ      = sync2_reg[gi] ^ sw_state_reg[gi];
         assign commit[gi]  = tick & differ & (cnt_reg == CNT_LAST);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (tick) begin
               if (!differ || (cnt_reg == CNT_LAST)) begin
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
         end
      end
   endgenerate

   // A commit always flips the level, and a new commit beats a grant clear.
   assign pending_next = (pending_reg & ~grant_clr) | commit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_state_reg <= '0;
         pending_reg  <= '0;
      end else begin
         sw_state_reg <= sw_state_reg ^ commit;
         pending_reg  <= pending_next;
      end
   end

   always_comb begin
      grant_found = 1'b0;
      grant_ch    = '0;
      scan_idx    = 0;
      for (int k = 0; k < N_CH; k++) begin
         scan_idx = int'(rr_ptr_reg) + k;
         if (scan_idx >= N_CH) begin
            scan_idx = scan_idx - N_CH;
         end
         if (!grant_found && pending_reg[scan_idx[CH_W-1:0]]) begin
            grant_found = 1'b1;
            grant_ch    = scan_idx[CH_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         evt_valid_reg <= 1'b0;
         evt_ch_reg    <= '0;
         evt_level_reg <= 1'b0;
         rr_ptr_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         evt_valid_reg <= evt_valid_next;
         evt_ch_reg    <= evt_ch_next;
         evt_level_reg <= evt_level_next;
         rr_ptr_reg    <= rr_ptr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      evt_valid_next = evt_valid_reg;
      evt_ch_next    = evt_ch_reg;
      evt_level_next = evt_level_reg;
      rr_ptr_next    = rr_ptr_reg;
      grant_clr      = '0;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               state_next          = PRESENT;
               evt_valid_next      = 1'b1;
               evt_ch_next         = grant_ch;
               evt_level_next      = sw_state_reg[grant_ch];
               grant_clr[grant_ch] = 1'b1;
            end
         end
         PRESENT: begin
            if (evt_ready) begin
               state_next     = IDLE;
               evt_valid_next = 1'b0;
               rr_ptr_next    = (evt_ch_reg == CH_LAST) ? '0 : evt_ch_reg + 1'b1;
            end
         end
         default: begin
            state_next     = IDLE;
            evt_valid_next = 1'b0;
         end
      endcase
   end

   assign sw_state  = sw_state_reg;
   assign evt_valid = evt_valid_reg;
   assign evt_ch    = evt_ch_reg;
   assign evt_level = evt_level_reg;

`ifdef SWITCH_EVT_OVERRUN_EN
   logic [N_CH-1:0] overrun_reg;

   // A new overrun in the same cycle as a clear still sticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_reg <= '0;
      end else begin
         overrun_reg <= (ovr_clr ? '0 : overrun_reg) | (commit & pending_reg);
      end
   end

   assign evt_overrun = overrun_reg;
`else
   logic unused_ovr_clr;

   assign unused_ovr_clr = ovr_clr;
   assign evt_overrun    = '0;
`endif

endmodule

// File: tb/tb_switch_event_scheduler.sv
// Directed bench for switch_event_scheduler with TICK_DIV=4, STABLE_CNT=3.
// Tick edges fall on cycles that are multiples of 4 after reset release.
module tb_switch_event_scheduler;
   localparam int N_CH = 17;
   localparam int CH_W = 5;
`ifdef SWITCH_EVT_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N_CH-1:0] sw_in = '0;
   logic [N_CH-1:0] sw_state;
   logic            evt_valid;
   logic            evt_ready = 1'b0;
   logic [CH_W-1:0] evt_ch;
   logic            evt_level;
   logic [N_CH-1:0] evt_overrun;
   logic            ovr_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   switch_event_scheduler #(
      .N_CH(N_CH), .CH_W(CH_W), .TICK_DIV(4), .STABLE_CNT(3)
   ) dut (
      .clk(clk), .rst(rst), .sw_in(sw_in), .sw_state(sw_state),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
      .evt_level(evt_level), .evt_overrun(evt_overrun), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready)
         $display("xfer cyc %0d ch %0d level %0d", cyc, evt_ch, evt_level);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic do_reset(input logic [N_CH-1:0] sw_init);
      rst = 1'b1; sw_in = sw_init; evt_ready = 1'b0; ovr_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      do_reset('1);
      while (cyc < 11) begin
         step();
         checks++;
         if (evt_valid !== 1'b0 || sw_state !== '0) begin
            errors++;
            $display("FAIL reset_no_early cyc %0d: valid=%b sw_state=%h required valid=0 sw_state=0", cyc, evt_valid, sw_state);
         end
      end
      step();
      checks++;
      if (sw_state !== 17'h1ffff) begin
         errors++; $display("FAIL reset_commit_all: sw_state=%h required 1ffff", sw_state);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd0 || evt_level !== 1'b1) begin
         errors++; $display("FAIL reset_first_evt: valid=%b ch=%0d level=%b required 1/0/1", evt_valid, evt_ch, evt_level);
      end
      #4 rst = 1'b1;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || sw_state !== '0 || evt_ch !== 5'd0 || evt_level !== 1'b0 || evt_overrun !== '0) begin
         errors++;
         $display("FAIL reset_async: valid=%b sw_state=%h ch=%0d level=%b ovr=%h required all 0", evt_valid, sw_state, evt_ch, evt_level, evt_overrun);
      end
      sw_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_single_event();
      do_reset('0);
      sw_in[3] = 1'b1;
      run_to(11);
      checks++;
      if (sw_state !== '0) begin
         errors++; $display("FAIL single_pre_commit: sw_state=%h required 0", sw_state);
      end
      step();
      checks++;
      if (sw_state !== 17'h8) begin
         errors++; $display("FAIL single_commit: sw_state=%h required 00008", sw_state);
      end
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_ch !== 5'd3 || evt_level !== 1'b1) begin
            errors++;
            $display("FAIL single_hold cyc %0d: valid=%b ch=%0d level=%b required 1/3/1", cyc, evt_valid, evt_ch, evt_level);
         end
         if (i < 4) step();
      end
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL single_release: valid=%b required 0", evt_valid);
      end
   endtask

   task automatic test_bounce();
      do_reset('0);
      for (int t = 0; t < 8; t++) begin
         sw_in[0] = (t % 2 == 0);
         repeat (4) begin
            step();
            checks++;
            if (sw_state !== '0 || evt_valid !== 1'b0) begin
               errors++;
               $display("FAIL bounce cyc %0d: sw_state=%h valid=%b required 0/0", cyc, sw_state, evt_valid);
            end
         end
      end
      sw_in[0] = 1'b0;
      repeat (16) begin
         step();
         checks++;
         if (sw_state !== '0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL bounce_tail cyc %0d: sw_state=%h valid=%b required 0/0", cyc, sw_state, evt_valid);
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset('0);
      evt_ready = 1'b1;
      sw_in[1] = 1'b1;
      sw_in[5] = 1'b1;
      run_to(13);
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd1 || evt_level !== 1'b1) begin
         errors++; $display("FAIL rr_first: valid=%b ch=%0d level=%b required 1/1/1", evt_valid, evt_ch, evt_level);
      end
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL rr_gap: valid=%b required 0", evt_valid);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd5 || evt_level !== 1'b1) begin
         errors++; $display("FAIL rr_second: valid=%b ch=%0d level=%b required 1/5/1", evt_valid, evt_ch, evt_level);
      end
      step();
      sw_in[0] = 1'b1;
      sw_in[7] = 1'b1;
      run_to(29);
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd7) begin
         errors++; $display("FAIL rr_ptr6_first: valid=%b ch=%0d required 1/7", evt_valid, evt_ch);
      end
      step();
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd0 || evt_level !== 1'b1) begin
         errors++; $display("FAIL rr_ptr6_second: valid=%b ch=%0d level=%b required 1/0/1", evt_valid, evt_ch, evt_level);
      end
      step();
      evt_ready = 1'b0;
   endtask

   task automatic test_overrun();
      do_reset('0);
      sw_in[2] = 1'b1;
      run_to(13);
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd2 || evt_level !== 1'b1) begin
         errors++; $display("FAIL ovr_grant: valid=%b ch=%0d level=%b required 1/2/1", evt_valid, evt_ch, evt_level);
      end
      sw_in[2] = 1'b0;
      run_to(24);
      checks++;
      if (sw_state !== '0 || evt_valid !== 1'b1 || evt_level !== 1'b1 || evt_overrun !== '0) begin
         errors++;
         $display("FAIL ovr_held: sw_state=%h valid=%b level=%b ovr=%h required 0/1/1/0", sw_state, evt_valid, evt_level, evt_overrun);
      end
      sw_in[2] = 1'b1;
      run_to(35);
      checks++;
      if (evt_overrun !== '0) begin
         errors++; $display("FAIL ovr_before: ovr=%h required 0", evt_overrun);
      end
      step();
      checks++;
      if (evt_overrun !== (OVR_EN ? 17'h4 : 17'h0)) begin
         errors++; $display("FAIL ovr_set: ovr=%h required %h", evt_overrun, OVR_EN ? 17'h4 : 17'h0);
      end
      run_to(40);
      checks++;
      if (evt_overrun !== (OVR_EN ? 17'h4 : 17'h0)) begin
         errors++; $display("FAIL ovr_sticky: ovr=%h required %h", evt_overrun, OVR_EN ? 17'h4 : 17'h0);
      end
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      checks++;
      if (evt_overrun !== '0) begin
         errors++; $display("FAIL ovr_clear: ovr=%h required 0", evt_overrun);
      end
      evt_ready = 1'b1;
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL ovr_release: valid=%b required 0", evt_valid);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd2 || evt_level !== 1'b1) begin
         errors++; $display("FAIL ovr_fresh_evt: valid=%b ch=%0d level=%b required 1/2/1", evt_valid, evt_ch, evt_level);
      end
      step();
      evt_ready = 1'b0;
   endtask

   task automatic test_wrap_set_wins();
      do_reset('0);
      sw_in[15] = 1'b1;
      sw_in[16] = 1'b1;
      run_to(13);
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd15 || evt_level !== 1'b1) begin
         errors++; $display("FAIL wrap_ch15: valid=%b ch=%0d level=%b required 1/15/1", evt_valid, evt_ch, evt_level);
      end
      sw_in[16] = 1'b0;
      run_to(22);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_release15: valid=%b required 0", evt_valid);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd16 || evt_level !== 1'b1) begin
         errors++; $display("FAIL wrap_ch16_first: valid=%b ch=%0d level=%b required 1/16/1", evt_valid, evt_ch, evt_level);
      end
      checks++;
      if (evt_overrun !== (OVR_EN ? 17'h10000 : 17'h0)) begin
         errors++; $display("FAIL wrap_ovr16: ovr=%h required %h", evt_overrun, OVR_EN ? 17'h10000 : 17'h0);
      end
      evt_ready = 1'b1;
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_gap: valid=%b required 0", evt_valid);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd16 || evt_level !== 1'b0) begin
         errors++; $display("FAIL wrap_ch16_second: valid=%b ch=%0d level=%b required 1/16/0", evt_valid, evt_ch, evt_level);
      end
      step();
      sw_in[0] = 1'b1;
      sw_in[1] = 1'b1;
      run_to(41);
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 5'd0) begin
         errors++; $display("FAIL wrap_ptr0: valid=%b ch=%0d required 1/0", evt_valid, evt_ch);
      end
      step();
      evt_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_bounce();
      test_round_robin();
      test_overrun();
      test_wrap_set_wins();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
